// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor.
// Operands are cut into BLOCK_WIDTH ripple blocks with skip muxes. Each
// pipeline stage evaluates BLOCKS_PER_STAGE blocks and registers the partial
// sum, the carry into the next block and the operand bits still to be used.
// A single stall signal freezes every stage while the output is held.

module pipelined_carry_skip_adder #(
    parameter int BIT_WIDTH        = 32,
    parameter int BLOCK_WIDTH      = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 cout,
    output logic                 overflow
);

    localparam int NUM_BLOCKS = (BIT_WIDTH + BLOCK_WIDTH - 1) / BLOCK_WIDTH;
    localparam int NUM_STAGES = (NUM_BLOCKS + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;
    localparam int PAD_WIDTH  = NUM_BLOCKS * BLOCK_WIDTH;
    localparam int LAST       = NUM_STAGES - 1;

    // Pipeline registers, one entry per stage.
    logic [PAD_WIDTH-1:0] opa_q   [NUM_STAGES];
    logic [PAD_WIDTH-1:0] opb_q   [NUM_STAGES];
    logic [PAD_WIDTH-1:0] sum_q   [NUM_STAGES];
    logic                 carry_q [NUM_STAGES];
    logic                 cmsb_q  [NUM_STAGES];
    logic                 valid_q [NUM_STAGES];

    // Inputs seen by each stage's combinational block evaluation.
    logic [PAD_WIDTH-1:0] stg_a     [NUM_STAGES];
    logic [PAD_WIDTH-1:0] stg_b     [NUM_STAGES];
    logic [PAD_WIDTH-1:0] stg_sum   [NUM_STAGES];
    logic                 stg_carry [NUM_STAGES];
    logic                 stg_cmsb  [NUM_STAGES];

    // Results of each stage's evaluation, captured by the stage register.
    logic [PAD_WIDTH-1:0] nx_sum   [NUM_STAGES];
    logic                 nx_carry [NUM_STAGES];
    logic                 nx_cmsb  [NUM_STAGES];

    logic [PAD_WIDTH-1:0] a_pad;
    logic [PAD_WIDTH-1:0] b_pad;
    logic                 c0;
    logic                 stall;
    logic                 c;
    logic                 cm;
    logic                 blk_cin;
    logic                 prop;
    logic                 p;

    assign stall     = valid_q[LAST] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST][BIT_WIDTH-1:0];
    assign cout      = carry_q[LAST];
    assign overflow  = carry_q[LAST] ^ cmsb_q[LAST];

    // Fold subtract into an add of ~b with forced carry-in; pad to whole blocks.
    always_comb begin
        a_pad = '0;
        b_pad = '0;
        a_pad[BIT_WIDTH-1:0] = a;
        b_pad[BIT_WIDTH-1:0] = sub ? ~b : b;
        c0 = sub | cin;
    end

    // Stage 0 works on the live operands, later stages on the previous register.
    always_comb begin
        stg_a[0]     = a_pad;
        stg_b[0]     = b_pad;
        stg_sum[0]   = '0;
        stg_carry[0] = c0;
        stg_cmsb[0]  = 1'b0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stg_a[k]     = opa_q[k-1];
            stg_b[k]     = opb_q[k-1];
            stg_sum[k]   = sum_q[k-1];
            stg_carry[k] = carry_q[k-1];
            stg_cmsb[k]  = cmsb_q[k-1];
        end
    end

    // Ripple each block of a stage, then let the skip mux bypass it when every bit propagates.
    always_comb begin
        c       = 1'b0;
        cm      = 1'b0;
        blk_cin = 1'b0;
        prop    = 1'b0;
        p       = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            nx_sum[k] = stg_sum[k];
            c         = stg_carry[k];
            cm        = stg_cmsb[k];
            for (int j = 0; j < BLOCKS_PER_STAGE; j++) begin
                if (k * BLOCKS_PER_STAGE + j < NUM_BLOCKS) begin
                    blk_cin = c;
                    prop    = 1'b1;
                    for (int i = 0; i < BLOCK_WIDTH; i++) begin
                        if ((k * BLOCKS_PER_STAGE + j) * BLOCK_WIDTH + i < BIT_WIDTH) begin
                            p = stg_a[k][(k * BLOCKS_PER_STAGE + j) * BLOCK_WIDTH + i]
                              ^ stg_b[k][(k * BLOCKS_PER_STAGE + j) * BLOCK_WIDTH + i];
                            if ((k * BLOCKS_PER_STAGE + j) * BLOCK_WIDTH + i == BIT_WIDTH - 1) begin
                                cm = c;
                            end
                            nx_sum[k][(k * BLOCKS_PER_STAGE + j) * BLOCK_WIDTH + i] = p ^ c;
                            c = (stg_a[k][(k * BLOCKS_PER_STAGE + j) * BLOCK_WIDTH + i]
                               & stg_b[k][(k * BLOCKS_PER_STAGE + j) * BLOCK_WIDTH + i]) | (p & c);
                            prop = prop & p;
                        end
                    end
                    if (k * BLOCKS_PER_STAGE + j == NUM_BLOCKS - 1) begin
                        prop = 1'b0;
                    end
                    if (prop) begin
                        c = blk_cin;
                    end
                end
            end
            nx_carry[k] = c;
            nx_cmsb[k]  = cm;
        end
    end

    // Advance every stage together unless the output is being held back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                valid_q[k] <= 1'b0;
                opa_q[k]   <= '0;
                opb_q[k]   <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                cmsb_q[k]  <= 1'b0;
            end
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < NUM_STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            for (int k = 0; k < NUM_STAGES; k++) begin
                opa_q[k]   <= stg_a[k];
                opb_q[k]   <= stg_b[k];
                sum_q[k]   <= nx_sum[k];
                carry_q[k] <= nx_carry[k];
                cmsb_q[k]  <= nx_cmsb[k];
            end
        end
    end

endmodule
